// File: rtl/data_path_pkg.sv
// Shared constants for the single-bus datapath: widths and ALU opcodes.
package data_path_pkg;

    localparam int WIDTH = 32;
    localparam int NREGS = 16;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_SHR  = 5'd4;
    localparam logic [4:0] ALU_SHRA = 5'd5;
    localparam logic [4:0] ALU_SHL  = 5'd6;
    localparam logic [4:0] ALU_ROR  = 5'd7;
    localparam logic [4:0] ALU_ROL  = 5'd8;
    localparam logic [4:0] ALU_MUL  = 5'd9;
    localparam logic [4:0] ALU_DIV  = 5'd10;
    localparam logic [4:0] ALU_NEG  = 5'd11;
    localparam logic [4:0] ALU_NOT  = 5'd12;

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: result = f(a, b). Only MUL and DIV populate the upper half.
module data_path_alu
    import data_path_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [4:0]     op,
    output logic [2*W-1:0] result
);

    logic signed [W-1:0]   a_s;
    logic signed [W-1:0]   b_s;
    logic [4:0]            sh;
    logic [2*W-1:0]        rot_r;
    logic [2*W-1:0]        rot_l;
    logic [W-1:0]          sra;
    logic signed [2*W-1:0] prod;
    logic signed [W-1:0]   quot;
    logic signed [W-1:0]   rem;

    // Operation select; rotates use a doubled operand so no wrap logic is needed.
    always_comb begin
        a_s    = a;
        b_s    = b;
        sh     = b[4:0];
        rot_r  = {a, a} >> sh;
        rot_l  = {a, a} << sh;
        sra    = a_s >>> sh;
        prod   = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        quot   = '0;
        rem    = '0;
        if (b != '0) begin
            quot = a_s / b_s;
            rem  = a_s % b_s;
        end
        result = '0;
        case (op)
            ALU_ADD:  result = {{W{1'b0}}, a + b};
            ALU_SUB:  result = {{W{1'b0}}, a - b};
            ALU_AND:  result = {{W{1'b0}}, a & b};
            ALU_OR:   result = {{W{1'b0}}, a | b};
            ALU_SHR:  result = {{W{1'b0}}, a >> sh};
            ALU_SHRA: result = {{W{1'b0}}, sra};
            ALU_SHL:  result = {{W{1'b0}}, a << sh};
            ALU_ROR:  result = {{W{1'b0}}, rot_r[W-1:0]};
            ALU_ROL:  result = {{W{1'b0}}, rot_l[2*W-1:W]};
            ALU_MUL:  result = prod;
            ALU_DIV:  result = {rem, quot};
            ALU_NEG:  result = {{W{1'b0}}, -b};
            ALU_NOT:  result = {{W{1'b0}}, ~b};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/data_path.sv
// Single-bus CPU datapath: register file, HI/LO/PC/MDR/Y/Z and a priority bus mux.
// All enables and selects come from an external control unit; there are no outputs.
module data_path
    import data_path_pkg::*;
#(
    parameter int WIDTH = data_path_pkg::WIDTH,
    parameter int NREGS = data_path_pkg::NREGS
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [NREGS-1:0] regEnable,
    input  logic             HiEn,
    input  logic             LoEn,
    input  logic             ZEn,
    input  logic             PCEn,
    input  logic             MDREn,
    input  logic             YEn,
    input  logic [NREGS-1:0] regSelect,
    input  logic             HiSel,
    input  logic             LoSel,
    input  logic             ZHiSel,
    input  logic             ZLoSel,
    input  logic             PCSel,
    input  logic             MDRSel,
    input  logic [WIDTH-1:0] Mdata,
    input  logic             MDRread,
    input  logic [4:0]       ALUcode,
    input  logic [WIDTH-1:0] temp,
    input  logic             tempEnable
);

    logic [WIDTH-1:0]   r [0:NREGS-1];
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   pc;
    logic [WIDTH-1:0]   mdr;
    logic [WIDTH-1:0]   y;
    logic [2*WIDTH-1:0] z;

    logic [WIDTH-1:0]   bus;
    logic [WIDTH-1:0]   mdr_d;
    logic [2*WIDTH-1:0] z_d;
    logic               reg_found;

    // Bus source priority: temp, then lowest-numbered selected register, then HI..MDR.
    always_comb begin
        bus       = '0;
        reg_found = 1'b0;
        if (tempEnable) begin
            bus = temp;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (!reg_found && regSelect[i]) begin
                    bus       = r[i];
                    reg_found = 1'b1;
                end
            end
            if (!reg_found) begin
                if (HiSel)       bus = hi;
                else if (LoSel)  bus = lo;
                else if (ZHiSel) bus = z[2*WIDTH-1:WIDTH];
                else if (ZLoSel) bus = z[WIDTH-1:0];
                else if (PCSel)  bus = pc;
                else if (MDRSel) bus = mdr;
            end
        end
    end

    // MDR input mux: memory read data or the bus.
    always_comb begin
        mdr_d = MDRread ? Mdata : bus;
    end

    data_path_alu #(.W(WIDTH)) alu (
        .a      (y),
        .b      (bus),
        .op     (ALUcode),
        .result (z_d)
    );

    // Register loads; clear wins over every enable.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NREGS; i++) r[i] <= '0;
            hi  <= '0;
            lo  <= '0;
            pc  <= '0;
            mdr <= '0;
            y   <= '0;
            z   <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (regEnable[i]) r[i] <= bus;
            end
            if (HiEn)  hi  <= bus;
            if (LoEn)  lo  <= bus;
            if (PCEn)  pc  <= bus;
            if (MDREn) mdr <= mdr_d;
            if (YEn)   y   <= bus;
            if (ZEn)   z   <= z_d;
        end
    end

endmodule

// File: tb/tb_data_path.sv
module tb_data_path;

    logic        clock = 1'b0;
    logic        clear;
    logic [15:0] regEnable;
    logic        HiEn, LoEn, ZEn, PCEn, MDREn, YEn;
    logic [15:0] regSelect;
    logic        HiSel, LoSel, ZHiSel, ZLoSel, PCSel, MDRSel;
    logic [31:0] Mdata;
    logic        MDRread;
    logic [4:0]  ALUcode;
    logic [31:0] temp;
    logic        tempEnable;

    always #5 clock = ~clock;

    data_path dut (
        .clock(clock), .clear(clear), .regEnable(regEnable),
        .HiEn(HiEn), .LoEn(LoEn), .ZEn(ZEn), .PCEn(PCEn), .MDREn(MDREn), .YEn(YEn),
        .regSelect(regSelect), .HiSel(HiSel), .LoSel(LoSel), .ZHiSel(ZHiSel),
        .ZLoSel(ZLoSel), .PCSel(PCSel), .MDRSel(MDRSel), .Mdata(Mdata),
        .MDRread(MDRread), .ALUcode(ALUcode), .temp(temp), .tempEnable(tempEnable)
    );

    localparam int ID_HI = 16, ID_LO = 17, ID_PC = 18, ID_MDR = 19;
    localparam int ID_Y = 20, ID_Z = 21, ID_BUS = 22;

    typedef struct {
        int          id;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] rp [16];
    for (genvar g = 0; g < 16; g++) begin : g_probe
        assign rp[g] = dut.r[g];
    end

    function automatic logic [63:0] probe(input int id);
        if (id < 16)      return {32'h0, rp[id]};
        case (id)
            ID_HI:   return {32'h0, dut.hi};
            ID_LO:   return {32'h0, dut.lo};
            ID_PC:   return {32'h0, dut.pc};
            ID_MDR:  return {32'h0, dut.mdr};
            ID_Y:    return {32'h0, dut.y};
            ID_Z:    return dut.z;
            ID_BUS:  return {32'h0, dut.bus};
            default: return 64'hx;
        endcase
    endfunction

    initial begin
        forever begin
            @(negedge clock);
            while (sb.size() > 0) begin
                exp_t e;
                logic [63:0] act;
                e   = sb.pop_front();
                act = probe(e.id);
                n_checks++;
                if (act === e.exp) n_pass++;
                else $display("FAIL %s: got 0x%016h expected 0x%016h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input int id, input logic [63:0] exp, input string name);
        exp_t e;
        e.id = id; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic idle();
        clear = 0; regEnable = '0; HiEn = 0; LoEn = 0; ZEn = 0; PCEn = 0; MDREn = 0; YEn = 0;
        regSelect = '0; HiSel = 0; LoSel = 0; ZHiSel = 0; ZLoSel = 0; PCSel = 0; MDRSel = 0;
        Mdata = '0; MDRread = 0; ALUcode = '0; temp = '0; tempEnable = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    task automatic load_y(input logic [31:0] v);
        temp = v; tempEnable = 1; YEn = 1;
        step();
    endtask

    task automatic alu_reg(input int src, input logic [4:0] op, input logic [63:0] exp, input string name);
        regSelect[src] = 1'b1; ZEn = 1; ALUcode = op;
        step();
        expect_val(ID_Z, exp, name);
        settle();
    endtask

    task automatic alu_temp(input logic [31:0] b, input logic [4:0] op, input logic [63:0] exp, input string name);
        temp = b; tempEnable = 1; ZEn = 1; ALUcode = op;
        step();
        expect_val(ID_Z, exp, name);
        settle();
    endtask

    initial begin
        idle();
        temp = 32'h1234_5678; tempEnable = 1; regEnable = 16'hFFFF; HiEn = 1; LoEn = 1;
        PCEn = 1; MDREn = 1; YEn = 1; ZEn = 1;
        step();
        clear = 1;
        step();
        expect_val(0, 0, "reset_r0");   expect_val(3, 0, "reset_r3");
        expect_val(8, 0, "reset_r8");   expect_val(15, 0, "reset_r15");
        expect_val(ID_HI, 0, "reset_hi"); expect_val(ID_LO, 0, "reset_lo");
        expect_val(ID_PC, 0, "reset_pc"); expect_val(ID_MDR, 0, "reset_mdr");
        expect_val(ID_Y, 0, "reset_y");   expect_val(ID_Z, 0, "reset_z");
        expect_val(ID_BUS, 0, "reset_bus_idle");
        settle();

        temp = 10; tempEnable = 1; regEnable[0] = 1'b1; step();
        temp = 15; tempEnable = 1; regEnable[8] = 1'b1; step();
        expect_val(0, 10, "load_r0");
        expect_val(8, 15, "load_r8");
        settle();

        n_checks++;
        if (dut.r[0] === 32'd10) n_pass++;
        else $display("FAIL direct_r0: got 0x%08h expected 0x%08h", dut.r[0], 32'd10);
        n_checks++;
        if (dut.r[8] === 32'd15) n_pass++;
        else $display("FAIL direct_r8: got 0x%08h expected 0x%08h", dut.r[8], 32'd15);

        regSelect[0] = 1'b1; YEn = 1;
        expect_val(ID_BUS, 10, "bus_from_r0");
        settle();
        step();
        expect_val(ID_Y, 10, "load_y_from_r0");
        settle();

        alu_reg(8, 5'd0,  64'd25,                  "alu_add");
        alu_reg(8, 5'd1,  64'h0000_0000_FFFF_FFFB, "alu_sub");
        alu_reg(8, 5'd2,  64'd10,                  "alu_and");
        alu_reg(8, 5'd3,  64'd15,                  "alu_or");
        alu_reg(8, 5'd6,  64'h0005_0000,           "alu_shl");
        alu_reg(8, 5'd8,  64'h0005_0000,           "alu_rol");
        alu_reg(8, 5'd4,  64'h0,                   "alu_shr");
        alu_reg(8, 5'd7,  64'h0014_0000,           "alu_ror");
        alu_reg(8, 5'd11, 64'h0000_0000_FFFF_FFF1, "alu_neg");
        alu_reg(8, 5'd12, 64'h0000_0000_FFFF_FFF0, "alu_not");
        alu_reg(8, 5'd13, 64'h0,                   "alu_op13_zero");
        alu_reg(8, 5'd8,  64'h0005_0000,           "alu_rol_again");
        alu_reg(8, 5'd31, 64'h0,                   "alu_op31_zero");

        load_y(32'hF000_000F);
        alu_temp(32'd4,  5'd8, 64'h0000_0000_0000_00FF, "alu_rol_wrap");
        alu_temp(32'd36, 5'd7, 64'h0000_0000_FF00_0000, "alu_ror_amt_b4_0");

        load_y(32'h8000_0000);
        alu_temp(32'd4, 5'd5, 64'h0000_0000_F800_0000, "alu_shra_neg");
        alu_temp(32'd4, 5'd4, 64'h0000_0000_0800_0000, "alu_shr_logical");
        alu_temp(32'hFFFF_FFFF, 5'd0, 64'h0000_0000_7FFF_FFFF, "alu_add_wrap");

        load_y(32'hFFFF_FFFA);
        alu_temp(32'd4, 5'd9,  64'hFFFF_FFFF_FFFF_FFE8, "alu_mul_signed");
        alu_temp(32'd4, 5'd10, 64'hFFFF_FFFE_FFFF_FFFF, "alu_div_signed");

        ZHiSel = 1; HiEn = 1; step();
        ZLoSel = 1; LoEn = 1; step();
        expect_val(ID_HI, 64'hFFFF_FFFE, "hi_from_zhi");
        expect_val(ID_LO, 64'hFFFF_FFFF, "lo_from_zlo");
        settle();

        alu_temp(32'd0, 5'd10, 64'h0, "alu_div_by_zero");

        MDRread = 1; Mdata = 32'hDEAD_BEEF; MDREn = 1; step();
        expect_val(ID_MDR, 64'hDEAD_BEEF, "mdr_from_mdata");
        settle();
        MDRSel = 1; regEnable[3] = 1'b1; step();
        expect_val(3, 64'hDEAD_BEEF, "r3_from_mdr");
        settle();

        n_checks++;
        if (dut.r[3] === 32'hDEAD_BEEF) n_pass++;
        else $display("FAIL direct_r3: got 0x%08h expected 0x%08h", dut.r[3], 32'hDEAD_BEEF);

        MDRread = 0; Mdata = 32'h5555_5555; temp = 32'h0000_1234; tempEnable = 1; MDREn = 1; step();
        expect_val(ID_MDR, 64'h1234, "mdr_from_bus");
        settle();

        temp = 32'hCAFE_0001; tempEnable = 1; PCEn = 1; step();
        PCSel = 1; regEnable[15] = 1'b1; step();
        expect_val(ID_PC, 64'hCAFE_0001, "pc_load");
        expect_val(15, 64'hCAFE_0001, "r15_from_pc");
        settle();

        regSelect = 16'h0108;
        expect_val(ID_BUS, 64'hDEAD_BEEF, "bus_lowest_reg_wins");
        settle();
        n_checks++;
        if (dut.bus === dut.r[3]) n_pass++;
        else $display("FAIL direct_bus_r3: got 0x%08h expected 0x%08h", dut.bus, dut.r[3]);
        regSelect = 16'h0100; tempEnable = 1; temp = 32'h0000_0077;
        expect_val(ID_BUS, 64'h77, "bus_temp_beats_reg");
        settle();
        idle();
        regSelect = 16'h0100; HiSel = 1;
        expect_val(ID_BUS, 15, "bus_reg_beats_hi");
        settle();
        idle();
        HiSel = 1; LoSel = 1; PCSel = 1;
        expect_val(ID_BUS, 64'hFFFF_FFFE, "bus_hi_beats_lo");
        settle();
        idle();
        ZLoSel = 1; PCSel = 1; MDRSel = 1;
        expect_val(ID_BUS, 64'h0, "bus_zlo_beats_pc");
        settle();
        idle();
        PCSel = 1; MDRSel = 1;
        expect_val(ID_BUS, 64'hCAFE_0001, "bus_pc_beats_mdr");
        settle();
        idle();

        load_y(32'd100);
        regSelect[8] = 1'b1; regEnable[8] = 1'b1; YEn = 1; step();
        expect_val(ID_Y, 15, "same_cycle_y_from_r8");
        expect_val(8, 15, "same_cycle_r8_rw");
        settle();

        step();
        expect_val(0, 10, "hold_r0");
        expect_val(ID_HI, 64'hFFFF_FFFE, "hold_hi");
        settle();

        clear = 1; temp = 32'd77; tempEnable = 1; regEnable[5] = 1'b1; PCEn = 1; step();
        expect_val(5, 0, "clear_beats_write_r5");
        expect_val(0, 0, "clear_r0");
        expect_val(ID_PC, 0, "clear_beats_pc_write");
        expect_val(ID_MDR, 0, "clear_mdr");
        settle();

        settle();
        if (n_pass != n_checks || n_checks < 12)
            $display("FAIL summary: got %0d passed expected %0d", n_pass, n_checks);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no summary expected completion");
        $fatal(1, "timeout");
    end

endmodule
